// File: rtl/serial_result_collector_if.sv
// Handshake bundle between a bit-serial result source, the collector and the
// downstream register-file/store path.
interface serial_result_collector_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       size;
  logic             sign_ext;
  logic             bit_in;
  logic             bit_en;
  logic             frame_end;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;
  logic             short_frame;

  modport master (
    output start, size, sign_ext, bit_in, bit_en, frame_end, ready,
    input  data, valid, busy, short_frame
  );

  modport slave (
    input  start, size, sign_ext, bit_in, bit_en, frame_end, ready,
    output data, valid, busy, short_frame
  );
endinterface

// File: rtl/serial_result_collector.sv
// Collects an LSB-first bit stream into a sized, sign/zero-extended word and
// offers it downstream over valid/ready.
module serial_result_collector #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_result_collector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, VALID} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [1:0]           size_q, size_d;
  logic                 sext_q, sext_d;
  logic                 short_q, short_d;
  logic                 lastBit_q, lastBit_d;
  logic [CNT_WIDTH-1:0] reqN;
  logic                 accept;
  logic                 openFrame;

  always_comb begin
    reqN = CNT_WIDTH'(WIDTH);
    unique case (size_q)
      2'b00:   reqN = CNT_WIDTH'(8);
      2'b01:   reqN = CNT_WIDTH'(16);
      default: reqN = CNT_WIDTH'(WIDTH);
    endcase
  end

  // A start in COLLECT, or alongside the handshake in VALID, reopens a frame
  // through the same path as a start from IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    size_d    = size_q;
    sext_d    = sext_q;
    short_d   = short_q;
    lastBit_d = lastBit_q;
    accept    = 1'b0;
    openFrame = 1'b0;

    unique case (state_q)
      IDLE: begin
        openFrame = bus.start;
      end
      COLLECT: begin
        if (bus.start) begin
          openFrame = 1'b1;
        end else begin
          accept = bus.bit_en && (cnt_q < reqN);
          if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (cnt_q == CNT_WIDTH'(i)) data_d[i] = bus.bit_in;
            end
            cnt_d     = cnt_q + 1'b1;
            lastBit_d = bus.bit_in;
          end
          // Fill happens on the closing edge so the first VALID cycle is final.
          if ((accept && (cnt_d == reqN)) || bus.frame_end) begin
            state_d = VALID;
            short_d = (cnt_d < reqN);
            for (int i = 0; i < WIDTH; i++) begin
              if (CNT_WIDTH'(i) >= reqN) data_d[i] = sext_q & lastBit_d;
            end
          end
        end
      end
      VALID: begin
        if (bus.ready) begin
          if (bus.start) openFrame = 1'b1;
          else           state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (openFrame) begin
      state_d   = COLLECT;
      cnt_d     = '0;
      data_d    = '0;
      short_d   = 1'b0;
      size_d    = bus.size;
      sext_d    = bus.sign_ext;
      lastBit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      size_q    <= 2'b10;
      sext_q    <= 1'b0;
      short_q   <= 1'b0;
      lastBit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      short_q   <= short_d;
      lastBit_q <= lastBit_d;
    end
  end

  assign bus.data        = data_q;
  assign bus.valid       = (state_q == VALID);
  assign bus.busy        = (state_q == COLLECT);
  assign bus.short_frame = short_q;

endmodule

// File: tb/tb_serial_result_collector.sv
// Directed bench for serial_result_collector: word/byte frames, gaps,
// backpressure, aborts and asynchronous reset.
module tb_serial_result_collector;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_result_collector_if #(.WIDTH(32)) bus ();

  serial_result_collector #(.WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are set 1ns after a rising edge, so the next edge consumes them and
  // the outputs are sampled 1ns after that edge.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic se,
                               input logic b, input logic en, input logic fe,
                               input logic rdy);
    bus.start     = st;
    bus.size      = sz;
    bus.sign_ext  = se;
    bus.bit_in    = b;
    bus.bit_en    = en;
    bus.frame_end = fe;
    bus.ready     = rdy;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
  endtask

  task automatic sendBits(input logic [31:0] v, input int first, input int last,
                          input logic rdy);
    for (int i = first; i <= last; i++) applyStimulus(1'b0, 2'b10, 1'b0, v[i], 1'b1, 1'b0, rdy);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expData,
                             input logic expValid, input logic expBusy,
                             input logic expShort);
    checks++;
    assert (bus.data === expData) else begin
      errors++;
      $error("[TB] FAIL %s data got %h exp %h", tag, bus.data, expData);
    end
    checks++;
    assert (bus.valid === expValid) else begin
      errors++;
      $error("[TB] FAIL %s valid got %b exp %b", tag, bus.valid, expValid);
    end
    checks++;
    assert (bus.busy === expBusy) else begin
      errors++;
      $error("[TB] FAIL %s busy got %b exp %b", tag, bus.busy, expBusy);
    end
    checks++;
    assert (bus.short_frame === expShort) else begin
      errors++;
      $error("[TB] FAIL %s short_frame got %b exp %b", tag, bus.short_frame, expShort);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.size      = 2'b00;
    bus.sign_ext  = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_en    = 1'b0;
    bus.frame_end = 1'b0;
    bus.ready     = 1'b0;
    #3;
    checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] idle ignores bit_en and frame_end");
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("idle ignore", 32'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] word frame 0xDEADBEEF");
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("word open", 32'h0, 1'b0, 1'b1, 1'b0);
    sendBits(32'hDEADBEEF, 0, 30, 1'b1);
    checkOutput("word 31 bits", 32'h5EADBEEF, 1'b0, 1'b1, 1'b0);
    sendBits(32'hDEADBEEF, 31, 31, 1'b1);
    checkOutput("word done", 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("word drained", 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);

    $display("[TB] gapped stream ended by frame_end");
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("gap idle bits", 32'h0, 1'b0, 1'b1, 1'b0);
    sendBits(32'h0123456, 0, 26, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("gap done", 32'h00123456, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] byte frames, signed then unsigned");
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(32'h80, 0, 7, 1'b0);
    checkOutput("byte signed", 32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
    sendBits(32'hFF, 0, 7, 1'b0);
    checkOutput("byte extras", 32'hFFFFFF80, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(32'h80, 0, 7, 1'b0);
    checkOutput("byte unsigned", 32'h00000080, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] half frame, short, bit and frame_end together");
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(32'h5, 0, 2, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("half short", 32'hFFFF000D, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(32'hA5A5A5A5, 0, 31, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus((i % 3) == 0, 2'b00, 1'b1, logic'(i % 2), logic'(i % 2), 1'b0, 1'b0);
    checkOutput("held", 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("handshake start", 32'h0, 1'b0, 1'b1, 1'b0);

    $display("[TB] zero-bit frame, sign_ext set");
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("zero bits", 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] start aborts an open frame");
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sendBits(32'hFFFFFFFF, 0, 9, 1'b1);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort reopen", 32'h0, 1'b0, 1'b1, 1'b0);
    sendBits(32'h3C, 0, 6, 1'b0);
    checkOutput("abort 7 bits", 32'h3C, 1'b0, 1'b1, 1'b0);
    sendBits(32'h3C, 7, 7, 1'b0);
    checkOutput("abort second", 32'h3C, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] asynchronous reset");
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(32'h1F, 0, 4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset collect", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(32'hA5, 0, 7, 1'b0);
    checkOutput("pre reset valid", 32'hFFFFFFA5, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset valid", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(32'h7F, 0, 7, 1'b0);
    checkOutput("after reset", 32'h0000007F, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("final idle", 32'h0000007F, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
